pulse_channel_gen: RTL and testbench

//  Parametrised pulse-wave voice, successor to the fixed 75%-duty channel-1 pulse generator.
//  - Adds selectable duty (12.5/25/50/75%), a decaying volume envelope, a length counter and a mute state.
//  - Sits between a note sequencer (note/volume/length writes) and the mixer (o_output).

---
 rtl/pulse_channel_gen_pkg.sv | 28 ++
 rtl/pulse_channel_gen_envelope_unit.sv | 95 +++++++++
 rtl/pulse_channel_gen.sv | 87 ++++++++
 tb/tb_pulse_channel_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_channel_gen_pkg.sv
// Shared definitions for the pulse voice: duty codes and duty threshold table.
package pulse_channel_gen_pkg;

  typedef enum logic [1:0] {
    DUTY_12 = 2'd0,
    DUTY_25 = 2'd1,
    DUTY_50 = 2'd2,
    DUTY_75 = 2'd3
  } duty_e;

  // Number of high eighths (out of 8) for each duty code.
  localparam logic [3:0] DUTY_THR_12 = 4'd1;
  localparam logic [3:0] DUTY_THR_25 = 4'd2;
  localparam logic [3:0] DUTY_THR_50 = 4'd4;
  localparam logic [3:0] DUTY_THR_75 = 4'd6;

  function automatic logic [3:0] duty_threshold(input duty_e duty);
    logic [3:0] thr;
    case (duty)
      DUTY_12: thr = DUTY_THR_12;
      DUTY_25: thr = DUTY_THR_25;
      DUTY_50: thr = DUTY_THR_50;
      default: thr = DUTY_THR_75;
    endcase
    return thr;
  endfunction

endpackage

// File: rtl/pulse_channel_gen_envelope_unit.sv
// Envelope unit: decay divider, saturating volume level, length counter and
// the voice-active flag. Note loads take priority over envelope ticks.
module envelope_unit
  import pulse_channel_gen_pkg::*;
#(
  parameter int OUT_W = 9,
  parameter int LEN_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_env_stb,
  input  logic             i_note_stb,
  input  logic [OUT_W-1:0] i_volume,
  input  logic             i_decay_en,
  input  logic [DIV_W-1:0] i_decay_period,
  input  logic [LEN_W-1:0] i_length,
  input  logic             i_length_en,
  output logic [OUT_W-1:0] o_level,
  output logic             o_active
);

  logic [OUT_W-1:0] level, level_n;
  logic [DIV_W-1:0] divider, divider_n;
  logic [DIV_W-1:0] period, period_n;
  logic [LEN_W-1:0] length, length_n;
  logic             decay_en, decay_en_n;
  logic             length_en, length_en_n;
  logic             active, active_n;

  // Level steps down by one but sticks at zero instead of wrapping to full scale.
  function automatic logic [OUT_W-1:0] sat_dec(input logic [OUT_W-1:0] v);
    return (v == '0) ? '0 : v - OUT_W'(1);
  endfunction

  // Next-state: note load, else envelope/length stepping on env ticks.
  always_comb begin
    level_n     = level;
    divider_n   = divider;
    period_n    = period;
    length_n    = length;
    decay_en_n  = decay_en;
    length_en_n = length_en;
    active_n    = active;
    if (i_note_stb) begin
      level_n     = i_volume;
      divider_n   = i_decay_period;
      period_n    = i_decay_period;
      length_n    = i_length;
      decay_en_n  = i_decay_en;
      length_en_n = i_length_en;
      active_n    = !(i_length_en && (i_length == '0));
    end else begin
      if (i_env_stb && decay_en) begin
        if (divider == '0) begin
          divider_n = period;
          level_n   = sat_dec(level);
        end else begin
          divider_n = divider - DIV_W'(1);
        end
      end
      if (i_env_stb && length_en && (length != '0)) begin
        length_n = length - LEN_W'(1);
        if (length_n == '0) active_n = 1'b0;
      end
      // A fully decayed envelope silences the voice on the same edge.
      if (decay_en && (level_n == '0)) active_n = 1'b0;
    end
  end

  // State register with synchronous reset of every field.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level     <= '0;
      divider   <= '0;
      period    <= '0;
      length    <= '0;
      decay_en  <= 1'b0;
      length_en <= 1'b0;
      active    <= 1'b0;
    end else begin
      level     <= level_n;
      divider   <= divider_n;
      period    <= period_n;
      length    <= length_n;
      decay_en  <= decay_en_n;
      length_en <= length_en_n;
      active    <= active_n;
    end
  end

  assign o_level  = level;
  assign o_active = active;

endmodule

// File: rtl/pulse_channel_gen.sv
// Pulse-wave voice: phase accumulator, selectable duty compare and a
// registered output sample gated by the envelope unit's level and active flag.
module pulse_channel_gen
  import pulse_channel_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 9,
  parameter int LEN_W   = 8,
  parameter int DIV_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick_stb,
  input  logic               i_env_stb,
  input  logic               i_note_stb,
  input  logic [PHASE_W-1:0] i_phase_delta,
  input  logic [1:0]         i_duty,
  input  logic [OUT_W-1:0]   i_volume,
  input  logic               i_decay_en,
  input  logic [DIV_W-1:0]   i_decay_period,
  input  logic [LEN_W-1:0]   i_length,
  input  logic               i_length_en,
  output logic [OUT_W-1:0]   o_output,
  output logic               o_frame_pulse,
  output logic               o_active
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] delta;
  duty_e              duty;
  logic [2:0]         eighth;
  logic               high_p0;
  logic [OUT_W-1:0]   level;
  logic               active;

  envelope_unit #(
    .OUT_W (OUT_W),
    .LEN_W (LEN_W),
    .DIV_W (DIV_W)
  ) u_env (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_env_stb      (i_env_stb),
    .i_note_stb     (i_note_stb),
    .i_volume       (i_volume),
    .i_decay_en     (i_decay_en),
    .i_decay_period (i_decay_period),
    .i_length       (i_length),
    .i_length_en    (i_length_en),
    .o_level        (level),
    .o_active       (active)
  );

  // Phase accumulator; a note load restarts the cycle and overrides a tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase <= '0;
      delta <= '0;
      duty  <= DUTY_12;
    end else if (i_note_stb) begin
      phase <= '0;
      delta <= i_phase_delta;
      duty  <= duty_e'(i_duty);
    end else if (i_tick_stb) begin
      phase <= phase + delta;
    end
  end

  // Duty compare on the top three phase bits (which eighth of the cycle).
  always_comb begin
    eighth  = phase[PHASE_W-1 -: 3];
    high_p0 = ({1'b0, eighth} < duty_threshold(duty));
  end

  // --- stage p0 -> p1: registered output sample ---
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_output <= '0;
    end else begin
      o_output <= (active && high_p0) ? level : '0;
    end
  end

  assign o_frame_pulse = phase[PHASE_W-1];
  assign o_active      = active;

endmodule

// File: tb/tb_pulse_channel_gen.sv
// Directed self-checking bench for pulse_channel_gen.
module tb_pulse_channel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_stb, env_stb, note_stb;
  logic [31:0] phase_delta;
  logic [1:0]  duty;
  logic [8:0]  volume;
  logic        decay_en;
  logic [3:0]  decay_period;
  logic [7:0]  length;
  logic        length_en;
  logic [8:0]  out_sample;
  logic        frame_pulse;
  logic        active;

  int checks = 0;
  int errors = 0;

  pulse_channel_gen #(
    .PHASE_W (32),
    .OUT_W   (9),
    .LEN_W   (8),
    .DIV_W   (4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_tick_stb     (tick_stb),
    .i_env_stb      (env_stb),
    .i_note_stb     (note_stb),
    .i_phase_delta  (phase_delta),
    .i_duty         (duty),
    .i_volume       (volume),
    .i_decay_en     (decay_en),
    .i_decay_period (decay_period),
    .i_length       (length),
    .i_length_en    (length_en),
    .o_output       (out_sample),
    .o_frame_pulse  (frame_pulse),
    .o_active       (active)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_note(input logic [31:0] d, input logic [1:0] dt, input logic [8:0] vol,
                           input logic de, input logic [3:0] per, input logic [7:0] len,
                           input logic le);
    phase_delta  = d;
    duty         = dt;
    volume       = vol;
    decay_en     = de;
    decay_period = per;
    length       = len;
    length_en    = le;
    note_stb     = 1'b1;
    step();
    note_stb     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (out_sample !== 9'd0) begin errors++; $display("FAIL rst_init_out: got %0d want 0", out_sample); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_init_active: got %b want 0", active); end
    checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL rst_init_frame: got %b want 0", frame_pulse); end
    reset = 1'b0;
    load_note(32'h8000_0000, 2'd3, 9'd77, 1'b0, 4'd0, 8'd0, 1'b0);
    tick_stb = 1'b1;
    step();
    tick_stb = 1'b0;
    step();
    checks++; if (frame_pulse !== 1'b1) begin errors++; $display("FAIL pre_rst_frame: got %b want 1", frame_pulse); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL pre_rst_active: got %b want 1", active); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_sample !== 9'd0) begin errors++; $display("FAIL rst_out[%0d]: got %0d want 0", i, out_sample); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active[%0d]: got %b want 0", i, active); end
      checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL rst_frame[%0d]: got %b want 0", i, frame_pulse); end
    end
    reset = 1'b0;
    // Delta was cleared by reset, so ticks must not move the phase.
    tick_stb = 1'b1;
    repeat (3) step();
    tick_stb = 1'b0;
    checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL post_rst_frame: got %b want 0", frame_pulse); end
    checks++; if (out_sample !== 9'd0) begin errors++; $display("FAIL post_rst_out: got %0d want 0", out_sample); end
  endtask

  task automatic test_duty_75();
    logic [8:0] exp_out;
    logic       exp_frame;
    load_note(32'h2000_0000, 2'd3, 9'd100, 1'b0, 4'd0, 8'd0, 1'b0);
    tick_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_out   = (i < 6) ? 9'd100 : 9'd0;
      exp_frame = (((i + 1) % 8) >= 4);
      checks++; if (out_sample !== exp_out) begin errors++; $display("FAIL duty75_out[%0d]: got %0d want %0d", i, out_sample, exp_out); end
      checks++; if (frame_pulse !== exp_frame) begin errors++; $display("FAIL duty75_frame[%0d]: got %b want %b", i, frame_pulse, exp_frame); end
    end
    tick_stb = 1'b0;
  endtask

  task automatic test_duty_sweep();
    int exp_hi[4] = '{1, 2, 4, 6};
    int cnt;
    for (int dt = 0; dt < 4; dt++) begin
      load_note(32'h2000_0000, 2'(dt), 9'd100, 1'b0, 4'd0, 8'd0, 1'b0);
      tick_stb = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step();
        if (out_sample == 9'd100) cnt++;
      end
      tick_stb = 1'b0;
      checks++; if (cnt != exp_hi[dt]) begin errors++; $display("FAIL duty_sweep[%0d]: high ticks %0d want %0d", dt, cnt, exp_hi[dt]); end
    end
  endtask

  task automatic test_field_latch();
    load_note(32'd0, 2'd3, 9'd40, 1'b0, 4'd0, 8'd0, 1'b0);
    step();
    checks++; if (out_sample !== 9'd40) begin errors++; $display("FAIL latch_base_out: got %0d want 40", out_sample); end
    volume      = 9'd99;
    duty        = 2'd0;
    phase_delta = 32'h8000_0000;
    tick_stb    = 1'b1;
    repeat (3) step();
    tick_stb    = 1'b0;
    checks++; if (out_sample !== 9'd40) begin errors++; $display("FAIL latch_out: got %0d want 40", out_sample); end
    checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL latch_frame: got %b want 0", frame_pulse); end
  endtask

  task automatic test_decay();
    int exp_lvl;
    load_note(32'd0, 2'd3, 9'd3, 1'b1, 4'd1, 8'd0, 1'b0);
    step();
    checks++; if (out_sample !== 9'd3) begin errors++; $display("FAIL decay_start: got %0d want 3", out_sample); end
    for (int k = 1; k <= 8; k++) begin
      env_stb = 1'b1;
      step();
      env_stb = 1'b0;
      exp_lvl = 3 - k / 2;
      if (exp_lvl < 0) exp_lvl = 0;
      checks++; if (active !== (exp_lvl > 0)) begin errors++; $display("FAIL decay_active[%0d]: got %b want %b", k, active, (exp_lvl > 0)); end
      step();
      checks++; if (out_sample !== 9'(exp_lvl)) begin errors++; $display("FAIL decay_level[%0d]: got %0d want %0d", k, out_sample, exp_lvl); end
      repeat (8) step();
    end
  endtask

  task automatic test_length();
    load_note(32'd0, 2'd3, 9'd50, 1'b0, 4'd0, 8'd2, 1'b1);
    step();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_start_active: got %b want 1", active); end
    checks++; if (out_sample !== 9'd50) begin errors++; $display("FAIL len_start_out: got %0d want 50", out_sample); end
    env_stb = 1'b1; step(); env_stb = 1'b0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL len_env1_active: got %b want 1", active); end
    repeat (9) step();
    env_stb = 1'b1; step(); env_stb = 1'b0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL len_env2_active: got %b want 0", active); end
    step();
    checks++; if (out_sample !== 9'd0) begin errors++; $display("FAIL len_end_out: got %0d want 0", out_sample); end
    load_note(32'd0, 2'd3, 9'd50, 1'b0, 4'd0, 8'd0, 1'b1);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL len_zero_active: got %b want 0", active); end
    load_note(32'd0, 2'd3, 9'd50, 1'b0, 4'd0, 8'd0, 1'b0);
    repeat (3) begin
      env_stb = 1'b1; step(); env_stb = 1'b0; step();
    end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL sustain_active: got %b want 1", active); end
    checks++; if (out_sample !== 9'd50) begin errors++; $display("FAIL sustain_out: got %0d want 50", out_sample); end
  endtask

  task automatic test_back_to_back();
    load_note(32'h8000_0000, 2'd3, 9'd9, 1'b0, 4'd0, 8'd0, 1'b0);
    tick_stb = 1'b1; step(); tick_stb = 1'b0;
    checks++; if (frame_pulse !== 1'b1) begin errors++; $display("FAIL b2b_pre_frame: got %b want 1", frame_pulse); end
    phase_delta  = 32'h8000_0000;
    duty         = 2'd3;
    volume       = 9'd5;
    decay_en     = 1'b1;
    decay_period = 4'd0;
    length       = 8'd2;
    length_en    = 1'b1;
    note_stb = 1'b1; tick_stb = 1'b1; env_stb = 1'b1;
    step();
    note_stb = 1'b0; tick_stb = 1'b0; env_stb = 1'b0;
    checks++; if (frame_pulse !== 1'b0) begin errors++; $display("FAIL b2b_phase: frame got %b want 0", frame_pulse); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL b2b_active: got %b want 1", active); end
    step();
    checks++; if (out_sample !== 9'd5) begin errors++; $display("FAIL b2b_level: got %0d want 5", out_sample); end
    env_stb = 1'b1; step(); env_stb = 1'b0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL b2b_env1_active: got %b want 1", active); end
    step();
    checks++; if (out_sample !== 9'd4) begin errors++; $display("FAIL b2b_env1_level: got %0d want 4", out_sample); end
    env_stb = 1'b1; step(); env_stb = 1'b0;
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL b2b_env2_active: got %b want 0", active); end
  endtask

  initial begin
    reset        = 1'b1;
    tick_stb     = 1'b0;
    env_stb      = 1'b0;
    note_stb     = 1'b0;
    phase_delta  = '0;
    duty         = '0;
    volume       = '0;
    decay_en     = 1'b0;
    decay_period = '0;
    length       = '0;
    length_en    = 1'b0;
    step();
    test_reset();
    test_duty_75();
    test_duty_sweep();
    test_field_latch();
    test_decay();
    test_length();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
